// File: rtl/debug_bus_arbiter.sv
// Round-robin owner of the shared debug register bus: grants one requester at a time,
// drives the transaction on the split-data bus and returns data or an error response.
module debug_bus_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255,
  localparam int GW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic [NUM_REQ-1:0]        rsp_valid_o,
  output logic [DATA_W-1:0]         rsp_data_o,
  output logic                      rsp_err_o,
  output logic [ADDR_W-1:0]         bus_addr_o,
  output logic [DATA_W-1:0]         bus_wdata_o,
  input  logic [DATA_W-1:0]         bus_rdata_i,
  input  logic                      bus_accepted_i,
  input  logic                      bus_available_i,
  output logic                      busy_o,
  output logic [GW-1:0]             grant_id_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  // Last counter value at which the bus may still answer; one more cycle means timeout.
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
  logic [NUM_REQ-1:0]  req_ready_q, req_ready_d;
  logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                rsp_err_q, rsp_err_d;
  logic                busy_q, busy_d;
  logic [GW-1:0]       grant_q, grant_d;
  logic [GW-1:0]       ptr_q, ptr_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [DATA_W-1:0]   pend_data_q, pend_data_d;
  logic                pend_err_q, pend_err_d;

  logic                sel_found_s;
  logic [GW-1:0]       sel_s;
  logic [ADDR_W-1:0]   sel_addr_s;
  logic [DATA_W-1:0]   sel_wdata_s;
  logic [15:0]         cnt_inc_s;
  logic                timeout_s;

  // Round-robin pick: first valid requester at or after ptr_q+1, wrapping.
  always_comb begin : p_select
    int idx;
    idx         = 0;
    sel_found_s = 1'b0;
    sel_s       = '0;
    sel_addr_s  = '0;
    sel_wdata_s = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (!sel_found_s && req_valid_i[idx]) begin
        sel_found_s = 1'b1;
        sel_s       = GW'(idx);
        sel_addr_s  = req_addr_i[idx*ADDR_W +: ADDR_W];
        sel_wdata_s = req_wdata_i[idx*DATA_W +: DATA_W];
      end else begin
        sel_found_s = sel_found_s;
      end
    end
  end

  assign cnt_inc_s = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
  assign timeout_s = (cnt_q >= TO_LAST);

  // Next-state and registered-output logic of the transaction sequencer.
  always_comb begin
    state_d     = state_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    req_ready_d = '0;
    rsp_valid_d = '0;
    rsp_data_d  = '0;
    rsp_err_d   = 1'b0;
    grant_d     = grant_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    pend_data_d = pend_data_q;
    pend_err_d  = pend_err_q;
    case (state_q)
      S_IDLE: begin
        bus_addr_d = '0;
        if (sel_found_s) begin
          req_ready_d[sel_s] = 1'b1;
          grant_d            = sel_s;
          ptr_d              = sel_s;
          if (sel_addr_s == '0) begin
            // Address 0 is the idle code, so it is answered with an error without a bus cycle.
            state_d     = S_RESP;
            pend_data_d = '0;
            pend_err_d  = 1'b1;
          end else begin
            state_d     = S_ISSUE;
            bus_addr_d  = sel_addr_s;
            bus_wdata_d = sel_wdata_s;
            cnt_d       = 16'd0;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        cnt_d = cnt_inc_s;
        if (bus_accepted_i && bus_available_i) begin
          state_d     = S_RESP;
          bus_addr_d  = '0;
          pend_data_d = bus_rdata_i;
          pend_err_d  = 1'b0;
        end else if (timeout_s) begin
          state_d     = S_RESP;
          bus_addr_d  = '0;
          pend_data_d = '0;
          pend_err_d  = 1'b1;
        end else if (bus_accepted_i) begin
          state_d = S_WAIT;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_inc_s;
        if (bus_available_i) begin
          state_d     = S_RESP;
          bus_addr_d  = '0;
          pend_data_d = bus_rdata_i;
          pend_err_d  = 1'b0;
        end else if (timeout_s) begin
          state_d     = S_RESP;
          bus_addr_d  = '0;
          pend_data_d = '0;
          pend_err_d  = 1'b1;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_RESP: begin
        bus_addr_d            = '0;
        rsp_valid_d[grant_q]  = 1'b1;
        rsp_data_d            = pend_data_q;
        rsp_err_d             = pend_err_q;
        state_d               = S_IDLE;
      end
      default: begin
        state_d    = S_IDLE;
        bus_addr_d = '0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset makes requester 0 the first in line.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      grant_q     <= '0;
      ptr_q       <= GW'(NUM_REQ - 1);
      cnt_q       <= 16'd0;
      pend_data_q <= '0;
      pend_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
      grant_q     <= grant_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      pend_data_q <= pend_data_d;
      pend_err_q  <= pend_err_d;
    end
  end

  assign req_ready_o = req_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_err_o   = rsp_err_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_wdata_o = bus_wdata_q;
  assign busy_o      = busy_q;
  assign grant_id_o  = grant_q;

endmodule

// File: tb/tb_debug_bus_arbiter.sv
// Self-checking bench for debug_bus_arbiter: directed vector table, hand-written corner
// sequences and a randomized run against a transaction-level reference model.
module tb_debug_bus_arbiter;
  localparam int NR = 3;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int TO = 8;
  localparam int GW = 2;

  logic             clk_i, rst_ni;
  logic [NR-1:0]    req_valid_i;
  logic [NR*AW-1:0] req_addr_i;
  logic [NR*DW-1:0] req_wdata_i;
  logic [NR-1:0]    req_ready_o, rsp_valid_o;
  logic [DW-1:0]    rsp_data_o;
  logic             rsp_err_o;
  logic [AW-1:0]    bus_addr_o;
  logic [DW-1:0]    bus_wdata_o;
  logic [DW-1:0]    bus_rdata_i;
  logic             bus_accepted_i, bus_available_i;
  logic             busy_o;
  logic [GW-1:0]    grant_id_o;

  debug_bus_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .req_ready_o(req_ready_o), .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o),
    .rsp_err_o(rsp_err_o), .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
    .bus_rdata_i(bus_rdata_i), .bus_accepted_i(bus_accepted_i),
    .bus_available_i(bus_available_i), .busy_o(busy_o), .grant_id_o(grant_id_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  // Peripheral behaviour: pulses at given ages (cycles since bus_addr went non-zero).
  int          p_acc, p_av, p_av2;
  logic        p_fix;
  logic [31:0] p_rd1, p_rd2;
  int          age = -1;

  typedef struct {
    int          id;
    logic [7:0]  addr;
    logic [31:0] wdata;
    int          acc, av, av2;
    logic [31:0] rd1, rd2;
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_lat;
    int          exp_bus;
  } vec_t;
  vec_t vt[10];

  function automatic logic [31:0] rd_f(input logic [7:0] a, input logic [31:0] w);
    return ({24'd0, a} * 32'h0100_0193) ^ w;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic periph();
    if (bus_addr_o != '0) age++;
    else age = -1;
    bus_accepted_i  = (age >= 0) && (age == p_acc);
    bus_available_i = (age >= 0) && (age == p_av || age == p_av2);
    if (bus_available_i)
      bus_rdata_i = p_fix ? ((age == p_av) ? p_rd1 : p_rd2) : rd_f(bus_addr_o, bus_wdata_o);
    else
      bus_rdata_i = $urandom;
  endtask

  // Drive the peripheral for the current cycle, then move to the next sampling point.
  task automatic nxt();
    periph();
    @(negedge clk_i);
  endtask

  task automatic set_req(input int i, input logic v, input logic [7:0] a, input logic [31:0] w);
    req_valid_i[i]          = v;
    req_addr_i[i*AW +: AW]  = a;
    req_wdata_i[i*DW +: DW] = w;
  endtask

  task automatic do_reset();
    rst_ni      = 1'b0;
    req_valid_i = '0;
    nxt();
    nxt();
    rst_ni = 1'b1;
    nxt();
  endtask

  task automatic wait_rsp(input string nm, input int id, input logic [31:0] d, input logic e);
    int k;
    k = 0;
    while (rsp_valid_o == '0 && k < 40) begin
      nxt();
      k++;
    end
    if (rsp_valid_o == '0) chk({nm, " rsp timeout"}, 64'd0, 64'd1);
    else begin
      chk({nm, " rsp id"}, rsp_valid_o, 64'd1 << id);
      chk({nm, " rsp data"}, rsp_data_o, d);
      chk({nm, " rsp err"}, rsp_err_o, e);
    end
  endtask

  task automatic run_vec(input vec_t v, input int n);
    int   k, bus_n;
    logic got;
    p_acc = v.acc; p_av = v.av; p_av2 = v.av2;
    p_fix = 1'b1; p_rd1 = v.rd1; p_rd2 = v.rd2;
    set_req(v.id, 1'b1, v.addr, v.wdata);
    nxt();
    chk($sformatf("v%0d req_ready", n), req_ready_o, 64'd1 << v.id);
    chk($sformatf("v%0d grant_id", n), grant_id_o, v.id);
    chk($sformatf("v%0d busy", n), busy_o, 1);
    req_valid_i[v.id] = 1'b0;
    bus_n = 0; got = 1'b0; k = 1;
    while (!got && k < 40) begin
      if (bus_addr_o != '0) begin
        bus_n++;
        chk($sformatf("v%0d bus_addr", n), bus_addr_o, v.addr);
        chk($sformatf("v%0d bus_wdata", n), bus_wdata_o, v.wdata);
      end
      if (k > 1 && req_ready_o != '0) chk($sformatf("v%0d extra ready", n), req_ready_o, 0);
      if (rsp_valid_o != '0) begin
        got = 1'b1;
        chk($sformatf("v%0d rsp id", n), rsp_valid_o, 64'd1 << v.id);
        chk($sformatf("v%0d rsp data", n), rsp_data_o, v.exp_data);
        chk($sformatf("v%0d rsp err", n), rsp_err_o, v.exp_err);
        chk($sformatf("v%0d latency", n), k, v.exp_lat);
      end else begin
        nxt();
        k++;
      end
    end
    if (!got) chk($sformatf("v%0d rsp timeout", n), 0, 1);
    chk($sformatf("v%0d bus cycles", n), bus_n, v.exp_bus);
    nxt();
    chk($sformatf("v%0d idle rsp", n), rsp_valid_o, 0);
    chk($sformatf("v%0d idle busy", n), busy_o, 0);
    chk($sformatf("v%0d idle bus", n), bus_addr_o, 0);
  endtask

  // Reference-model state for the random run.
  logic [NR-1:0] prev_v;
  int            last_g, n_txn;
  logic          t_act;
  int            t_id, t_start, t_end, t_rsp;
  logic [7:0]    t_addr;
  logic [31:0]   t_data;
  logic          t_err;
  logic          pend[NR], outs[NR];
  logic [7:0]    r_addr[NR];
  logic [31:0]   r_wd[NR];
  int            wait_age[NR];

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ng, nr, j, tt, seen;
    logic [31:0] wa, wb;

    rst_ni = 1'b0; req_valid_i = '0; req_addr_i = '0; req_wdata_i = '0;
    bus_rdata_i = '0; bus_accepted_i = 1'b0; bus_available_i = 1'b0;
    p_acc = -1; p_av = -1; p_av2 = -1; p_fix = 1'b0; p_rd1 = '0; p_rd2 = '0;

    vt[0] = '{0, 8'h01, 32'd5,  1,  3, -1, 32'd17,        32'd0,   32'd17,        1'b0, 6,  4};
    vt[1] = '{1, 8'h09, 32'h0, -1, -1, -1, 32'd0,         32'd0,   32'd0,         1'b1, 10, 8};
    vt[2] = '{0, 8'h00, 32'h1234, 0, 0, -1, 32'h99,       32'd0,   32'd0,         1'b1, 2,  0};
    vt[3] = '{2, 8'h44, 32'hA,  0,  0, -1, 32'hDEADBEEF,  32'd0,   32'hDEADBEEF,  1'b0, 3,  1};
    vt[4] = '{1, 8'h80, 32'hB,  1,  0,  4, 32'd111,       32'd222, 32'd222,       1'b0, 7,  5};
    vt[5] = '{0, 8'hFF, 32'hC,  0,  7, -1, 32'hCAFE,      32'd0,   32'hCAFE,      1'b0, 10, 8};
    vt[6] = '{2, 8'h03, 32'hD,  2,  1, -1, 32'h77,        32'd0,   32'd0,         1'b1, 10, 8};
    vt[7] = '{1, 8'h05, 32'hE,  3,  3, -1, 32'h1111,      32'd0,   32'h1111,      1'b0, 6,  4};
    vt[8] = '{2, 8'h10, 32'hF,  7,  7, -1, 32'h2222,      32'd0,   32'h2222,      1'b0, 10, 8};
    vt[9] = '{0, 8'h02, 32'h10, 7, -1, -1, 32'd0,         32'd0,   32'd0,         1'b1, 10, 8};

    nxt(); nxt();
    chk("reset bus_addr", bus_addr_o, 0);
    chk("reset bus_wdata", bus_wdata_o, 0);
    chk("reset req_ready", req_ready_o, 0);
    chk("reset rsp_valid", rsp_valid_o, 0);
    chk("reset rsp_data", rsp_data_o, 0);
    chk("reset rsp_err", rsp_err_o, 0);
    chk("reset busy", busy_o, 0);
    chk("reset grant_id", grant_id_o, 0);
    rst_ni = 1'b1;
    nxt();
    chk("post-reset idle", busy_o, 0);

    for (int i = 0; i < 10; i++) run_vec(vt[i], i);

    // Reset while waiting for an absent peripheral.
    p_acc = 0; p_av = -1; p_av2 = -1; p_fix = 1'b0;
    set_req(2, 1'b1, 8'h33, 32'h55);
    nxt();
    req_valid_i[2] = 1'b0;
    nxt(); nxt();
    chk("mid busy before reset", busy_o, 1);
    chk("mid bus_addr before reset", bus_addr_o, 8'h33);
    rst_ni = 1'b0;
    #1;
    chk("mid reset bus_addr", bus_addr_o, 0);
    chk("mid reset busy", busy_o, 0);
    chk("mid reset grant_id", grant_id_o, 0);
    nxt(); nxt();
    rst_ni = 1'b1;
    for (int i = 0; i < 4; i++) begin
      nxt();
      chk("mid no response", rsp_valid_o, 0);
    end
    p_acc = 0; p_av = 0;
    set_req(0, 1'b1, 8'h21, 32'h0A0A);
    set_req(1, 1'b1, 8'h22, 32'h0B0B);
    set_req(2, 1'b1, 8'h23, 32'h0C0C);
    nxt();
    chk("post-reset first grant", req_ready_o, 3'b001);
    req_valid_i = '0;
    wait_rsp("post-reset", 0, rd_f(8'h21, 32'h0A0A), 1'b0);

    // Two requesters holding their requests must alternate.
    do_reset();
    p_acc = 0; p_av = 0; p_av2 = -1; p_fix = 1'b0;
    wa = 32'h1357_9BDF; wb = 32'h2468_ACE0;
    set_req(0, 1'b1, 8'h01, wa);
    set_req(1, 1'b1, 8'h02, wb);
    ng = 0; nr = 0;
    for (int c = 0; c < 80 && nr < 4; c++) begin
      nxt();
      if (req_ready_o != '0) begin
        chk($sformatf("rr grant%0d", ng), req_ready_o, 64'd1 << (ng % 2));
        ng++;
        if (ng == 4) req_valid_i = '0;
      end
      if (rsp_valid_o != '0) begin
        chk($sformatf("rr rsp%0d id", nr), rsp_valid_o, 64'd1 << (nr % 2));
        chk($sformatf("rr rsp%0d data", nr), rsp_data_o,
            (nr % 2 == 1) ? rd_f(8'h02, wb) : rd_f(8'h01, wa));
        nr++;
      end
    end
    chk("rr responses", nr, 4);
    nxt(); nxt();

    // Randomized traffic against the transaction-level model.
    do_reset();
    last_g = NR - 1; n_txn = 0; t_act = 1'b0; prev_v = '0;
    t_id = 0; t_start = 0; t_end = 0; t_rsp = 0; t_addr = '0; t_data = '0; t_err = 1'b0;
    for (int i = 0; i < NR; i++) begin
      pend[i] = 1'b0; outs[i] = 1'b0; wait_age[i] = 0; r_addr[i] = '0; r_wd[i] = '0;
    end
    for (int c = 0; c < 3000; c++) begin
      if (rsp_valid_o != '0) begin
        if (!t_act) chk("rnd unexpected rsp", rsp_valid_o, 0);
        else begin
          chk("rnd rsp cycle", c, t_rsp);
          chk("rnd rsp id", rsp_valid_o, 64'd1 << t_id);
          chk("rnd rsp data", rsp_data_o, t_data);
          chk("rnd rsp err", rsp_err_o, t_err);
          outs[t_id] = 1'b0; t_act = 1'b0; n_txn++;
        end
      end else if (t_act && c > t_rsp) begin
        chk("rnd missing rsp", 0, 1);
        outs[t_id] = 1'b0; t_act = 1'b0;
      end
      if (req_ready_o != '0) begin
        j = -1;
        for (int k = 1; k <= NR; k++)
          if (j < 0 && prev_v[(last_g + k) % NR]) j = (last_g + k) % NR;
        if (t_act || j < 0) chk("rnd unexpected grant", req_ready_o, 0);
        else begin
          chk("rnd grant", req_ready_o, 64'd1 << j);
          chk("rnd grant_id", grant_id_o, j);
          last_g = j;
          pend[j] = 1'b0; outs[j] = 1'b1; wait_age[j] = 0;
          req_valid_i[j] = 1'b0;
          p_acc = $urandom_range(0, 4);
          p_av  = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, 8));
          p_av2 = -1; p_fix = 1'b0;
          t_act = 1'b1; t_id = j; t_addr = r_addr[j]; t_start = c;
          if (r_addr[j] == '0) begin
            t_end = c - 1; t_rsp = c + 1; t_data = '0; t_err = 1'b1;
          end else begin
            seen = 0; tt = -1;
            for (int t = 0; t < TO; t++) begin
              if (t == p_acc) seen = 1;
              if (tt < 0 && seen == 1 && t == p_av) tt = t;
            end
            if (tt >= 0) begin
              t_data = rd_f(r_addr[j], r_wd[j]); t_err = 1'b0;
            end else begin
              tt = TO - 1; t_data = '0; t_err = 1'b1;
            end
            t_end = c + tt; t_rsp = c + tt + 2;
          end
        end
      end
      chk("rnd bus_addr", bus_addr_o,
          (t_act && c >= t_start && c <= t_end) ? t_addr : 8'h00);
      for (int i = 0; i < NR; i++) begin
        if (pend[i]) begin
          wait_age[i]++;
          if (wait_age[i] > NR * (TO + 4) + 4) begin
            chk($sformatf("rnd starvation req%0d", i), wait_age[i], 0);
            wait_age[i] = 0;
          end
        end else if (!outs[i] && $urandom_range(0, 3) == 0) begin
          pend[i]   = 1'b1;
          r_addr[i] = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
          r_wd[i]   = $urandom;
          set_req(i, 1'b1, r_addr[i], r_wd[i]);
        end
      end
      prev_v = req_valid_i;
      nxt();
    end
    chk("rnd enough transactions", (n_txn > 100) ? 1 : 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/debug_bus_arbiter.md
Name: debug_bus_arbiter

Overview:
- Shares the single debug register bus between up to NUM_REQ debug requesters, for example the serial debug controller and an on-chip self-test sequencer.
- Grants requesters round-robin and sequences each bus transaction: issue, wait for accepted, wait for available, return data.
- Includes a timeout so an absent peripheral cannot hang the bus.
- Sits between the requesters and the peripheral side of the debug bus, which uses split data lines.

Parameters:
- NUM_REQ, 2, number of requesters (1..8).
- ADDR_W, 8, debug bus address width; address 0 means bus idle.
- DATA_W, 32, debug bus data width.
- TIMEOUT, 255, max cycles from issue to available before an error response (1..65535).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester transaction request.
- req_addr  in  NUM_REQ*ADDR_W  per-requester target address; requester i uses slice i.
- req_wdata  in  NUM_REQ*DATA_W  per-requester write data; requester i uses slice i.
- req_ready  out  NUM_REQ  one-cycle pulse: request of requester i latched.
- rsp_valid  out  NUM_REQ  one-cycle pulse: response for requester i.
- rsp_data  out  DATA_W  response data; valid while any rsp_valid bit is high.
- rsp_err  out  1  error flag; valid with rsp_valid.
- bus_addr  out  ADDR_W  registered bus address; 0 when no transaction is active.
- bus_wdata  out  DATA_W  registered bus write data.
- bus_rdata  in  DATA_W  peripheral read data.
- bus_accepted  in  1  peripheral has taken bus_wdata.
- bus_available  in  1  peripheral bus_rdata is valid.
- busy  out  1  high in any state other than IDLE.
- grant_id  out  clog2(NUM_REQ) (min 1)  index of the current/last granted requester.

Behaviour:
- Reset (rst low, asynchronous) clears all of the following immediately:
  - state to IDLE, bus_addr 0, bus_wdata 0;
  - req_ready 0, rsp_valid 0, rsp_data 0, rsp_err 0;
  - busy 0, grant_id 0;
  - rr pointer set so requester 0 has highest priority.
- A transaction aborted by reset produces no response.
- All outputs are registered.
- State machine: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - bus_addr is 0.
  - If any req_valid is set, select the first set bit at or after (last_grant+1) mod NUM_REQ.
  - Latch that requester's addr/wdata and pulse its req_ready for 1 cycle.
  - Update grant_id and last_grant.
  - If the latched addr is 0, go to RESP with err=1 and data 0; the bus is not touched.
  - Otherwise go to ISSUE.
- ISSUE:
  - Drive bus_addr and bus_wdata with the latched values.
  - Clear the timeout counter on entry.
  - bus_accepted=1 -> WAIT.
  - bus_accepted=1 and bus_available=1 in the same cycle -> capture bus_rdata, go straight to RESP with err=0.
  - bus_available without bus_accepted is ignored.
- WAIT:
  - bus_addr and bus_wdata are held.
  - bus_available=1 -> capture bus_rdata, go to RESP with err=0.
  - bus_accepted is ignored.
- Timeout:
  - Counter increments every cycle in ISSUE and WAIT and saturates.
  - When the count reaches TIMEOUT without bus_available, go to RESP with err=1 and rsp_data 0.
  - If bus_available and the timeout occur in the same cycle, bus_available wins.
- RESP:
  - bus_addr is 0.
  - Pulse rsp_valid[grant_id] for 1 cycle with rsp_data/rsp_err, then go to IDLE.
- Minimum idle gap between transactions: bus_addr is 0 for at least 2 cycles (RESP + IDLE).
- Latency: a request seen in IDLE cycle N produces:
  - req_ready in cycle N+1;
  - bus_addr valid from N+1;
  - fastest response (accepted+available on the first ISSUE cycle) has rsp_valid in N+3.
- Requester rules:
  - A requester holds req_valid/addr/wdata stable until req_ready.
  - It may drop req_valid the cycle after req_ready.
  - It must not re-request before its rsp_valid. The arbiter does not check this; a re-request before rsp_valid gives undefined ordering.
- Round-robin: a requester that holds req_valid continuously gets a grant within NUM_REQ transactions.
- req_valid changes during ISSUE, WAIT or RESP have no effect until the next IDLE.

Test Plan:
- Single request, transaction completes normally:
  - Stimulus: req0 addr=1, wdata=5; peripheral model asserts accepted 1 cycle after issue and available 2 cycles later with rdata=17.
  - Required: one req_ready[0] pulse; bus_addr=1 throughout ISSUE/WAIT; rsp_valid[0] once with rsp_data=17, err=0; bus_addr returns to 0.
- Round-robin fairness:
  - Stimulus: req0 and req1 held continuously, addr 1 and 2.
  - Required: grants alternate 0,1,0,1 over 4 transactions; each rsp_valid goes to the matching index with the correct data.
- Timeout:
  - Stimulus: TIMEOUT=8, req1 addr=9, peripheral never responds.
  - Required: rsp_valid[1] with err=1, data 0, exactly 8 cycles after ISSUE entry; next request proceeds normally.
- Address 0:
  - Stimulus: req0 addr=0.
  - Required: req_ready[0], then rsp_valid[0] with err=1 two cycles after the request; bus_addr stays 0 throughout.
- Same-cycle accepted and available:
  - Stimulus: accepted and available both asserted on the first ISSUE cycle, rdata=0xDEADBEEF.
  - Required: rsp_valid in N+3 with data 0xDEADBEEF; bus_available asserted in ISSUE without accepted is ignored.
- Reset mid-transaction:
  - Stimulus: rst low during WAIT.
  - Required: bus_addr and busy go to 0 immediately; no rsp_valid; after release, the next request is granted to requester 0 first.
